// File: rtl/rd_path_models.sv
// Read-path models around the tile loader: burst address generator, DMA read model,
// and a two-bank ping-pong buffer with independent fill and consume sides.
module rd_path_models #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CLOG2           = 0,
    parameter int MAX_BEATS       = 16,
    parameter int RD_LAT          = 2,
    parameter int DEPTH           = 256,
    parameter int USE_CONS_COMMIT = 1,
    parameter int PAW             = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ag_start,
    input  logic [ADDR_W-1:0] ag_base_addr,
    input  logic [31:0]       ag_bytes_total,
    input  logic [31:0]       ag_stride_bytes,
    output logic              ag_req_valid,
    input  logic              ag_req_ready,
    output logic [ADDR_W-1:0] ag_req_addr,
    output logic [7:0]        ag_req_len,
    output logic              ag_req_last,
    output logic              ag_done,
    input  logic              rd_start_dma,
    input  logic [ADDR_W-1:0] rd_start_addr,
    input  logic [7:0]        rd_num_trans,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              rd_done,
    input  logic [31:0]       seg_words,
    input  logic              fill_req,
    output logic              fill_busy,
    input  logic              fill_we,
    input  logic [PAW-1:0]    fill_addr,
    input  logic [DATA_W-1:0] fill_wdata,
    output logic              fill_done,
    input  logic              consume_req,
    output logic              consume_busy,
    input  logic              rd_en,
    input  logic [PAW-1:0]    rd_addr,
    output logic [DATA_W-1:0] rd_rdata,
    input  logic              cons_commit,
    output logic              consume_done,
    output logic              bank_sel,
    output logic [1:0]        o_dbg_ag_state,
    output logic [1:0]        o_dbg_dma_state,
    output logic [3:0]        o_dbg_bank_st
);
    localparam int BEAT_BYTES = (CLOG2 == 0) ? DATA_W / 8 : (1 << CLOG2);
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);

    // A burst request holds valid with stable addr/len/last until ready; it
    // transfers on any clock edge where valid and ready are both high.
    typedef enum logic [1:0] {AG_IDLE, AG_BURST, AG_DONE} ag_state_t;
    ag_state_t         r_ag_state, w_ag_next;
    logic [ADDR_W-1:0] r_ag_addr;
    logic [31:0]       r_ag_rem, r_ag_stride, w_ag_burst;
    logic [32:0]       w_ag_beats;
    logic              w_ag_last, w_ag_hs;

    assign w_ag_beats = ({1'b0, ag_bytes_total} + 33'(BEAT_BYTES - 1)) >> BEAT_SH;
    assign w_ag_burst = (r_ag_rem > 32'(MAX_BEATS)) ? 32'(MAX_BEATS) : r_ag_rem;
    assign w_ag_last  = (r_ag_rem <= 32'(MAX_BEATS));
    assign w_ag_hs    = (r_ag_state == AG_BURST) && ag_req_ready;

    always_comb begin
        w_ag_next = r_ag_state;
        case (r_ag_state)
            AG_IDLE:  if (ag_start) w_ag_next = (w_ag_beats == '0) ? AG_DONE : AG_BURST;
            AG_BURST: if (w_ag_hs && w_ag_last) w_ag_next = AG_DONE;
            AG_DONE:  w_ag_next = AG_IDLE;
            default:  w_ag_next = AG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ag_state  <= AG_IDLE;
            r_ag_addr   <= '0;
            r_ag_rem    <= '0;
            r_ag_stride <= '0;
        end else begin
            r_ag_state <= w_ag_next;
            if (r_ag_state == AG_IDLE && ag_start) begin
                r_ag_addr   <= ag_base_addr;
                r_ag_rem    <= w_ag_beats[31:0];
                r_ag_stride <= ag_stride_bytes;
            end else if (w_ag_hs) begin
                r_ag_addr <= r_ag_addr + ADDR_W'(w_ag_burst << BEAT_SH) + ADDR_W'(r_ag_stride);
                r_ag_rem  <= r_ag_rem - w_ag_burst;
            end
        end
    end

    assign ag_req_valid   = (r_ag_state == AG_BURST);
    assign ag_req_addr    = ag_req_valid ? r_ag_addr : '0;
    assign ag_req_len     = ag_req_valid ? 8'(w_ag_burst - 32'd1) : '0;
    assign ag_req_last    = ag_req_valid && w_ag_last;
    assign ag_done        = (r_ag_state == AG_DONE);
    assign o_dbg_ag_state = r_ag_state;

    typedef enum logic [1:0] {DMA_IDLE, DMA_WAIT, DMA_DATA, DMA_DONE} dma_state_t;
    dma_state_t        r_dma_state, w_dma_next;
    logic [DATA_W-1:0] r_dma_data;
    logic [7:0]        r_dma_rem, r_dma_lat;

    always_comb begin
        w_dma_next = r_dma_state;
        case (r_dma_state)
            DMA_IDLE: if (rd_start_dma) begin
                if (rd_num_trans == 8'd0) w_dma_next = DMA_DONE;
                else if (RD_LAT <= 1)     w_dma_next = DMA_DATA;
                else                      w_dma_next = DMA_WAIT;
            end
            DMA_WAIT: if (r_dma_lat <= 8'd1) w_dma_next = DMA_DATA;
            DMA_DATA: if (r_dma_rem == 8'd1) w_dma_next = DMA_DONE;
            DMA_DONE: w_dma_next = DMA_IDLE;
            default:  w_dma_next = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dma_state <= DMA_IDLE;
            r_dma_data  <= '0;
            r_dma_rem   <= '0;
            r_dma_lat   <= '0;
        end else begin
            r_dma_state <= w_dma_next;
            case (r_dma_state)
                DMA_IDLE: if (rd_start_dma) begin
                    r_dma_data <= DATA_W'(rd_start_addr);
                    r_dma_rem  <= rd_num_trans;
                    r_dma_lat  <= 8'(RD_LAT - 1);
                end
                DMA_WAIT: r_dma_lat <= r_dma_lat - 8'd1;
                DMA_DATA: begin
                    r_dma_data <= r_dma_data + DATA_W'(BEAT_BYTES);
                    r_dma_rem  <= r_dma_rem - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign rd_data_vld     = (r_dma_state == DMA_DATA);
    assign rd_data         = rd_data_vld ? r_dma_data : '0;
    assign rd_done         = (r_dma_state == DMA_DONE);
    assign o_dbg_dma_state = r_dma_state;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_CONSUMING} bank_t;
    bank_t             r_bank [2];
    bank_t             w_bank_nxt [2];
    logic              r_fill_ptr, r_cons_ptr, r_fill_pend, r_fill_busy, r_fill_done;
    logic              r_cons_busy, r_cons_done, r_bank_sel;
    logic [31:0]       r_fill_cnt, r_rd_cnt;
    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_fill_grant, w_fill_wr, w_fill_fin, w_cons_grant, w_cons_rd, w_cons_rel;

    // A refused fill_req is remembered; a refused consume_req is simply dropped.
    assign w_fill_grant = (fill_req || r_fill_pend) && !r_fill_busy && (r_bank[r_fill_ptr] == B_EMPTY);
    assign w_fill_wr    = fill_we && r_fill_busy;
    assign w_fill_fin   = w_fill_wr && ((r_fill_cnt + 32'd1) == seg_words);
    assign w_cons_grant = consume_req && !r_cons_busy && (r_bank[r_cons_ptr] == B_FULL);
    assign w_cons_rd    = rd_en && r_cons_busy;
    assign w_cons_rel   = (USE_CONS_COMMIT != 0) ? (cons_commit && r_cons_busy)
                                                 : (w_cons_rd && ((r_rd_cnt + 32'd1) == seg_words));

    always_comb begin
        w_bank_nxt[0] = r_bank[0];
        w_bank_nxt[1] = r_bank[1];
        if (w_fill_grant) w_bank_nxt[r_fill_ptr] = B_FILLING;
        if (w_fill_fin)   w_bank_nxt[r_fill_ptr] = B_FULL;
        if (w_cons_grant) w_bank_nxt[r_cons_ptr] = B_CONSUMING;
        if (w_cons_rel)   w_bank_nxt[r_cons_ptr] = B_EMPTY;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bank[0]   <= B_EMPTY;
            r_bank[1]   <= B_EMPTY;
            r_fill_ptr  <= 1'b0;
            r_cons_ptr  <= 1'b0;
            r_fill_pend <= 1'b0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_cons_busy <= 1'b0;
            r_cons_done <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_fill_cnt  <= '0;
            r_rd_cnt    <= '0;
            r_rdata     <= '0;
        end else begin
            r_bank[0]   <= w_bank_nxt[0];
            r_bank[1]   <= w_bank_nxt[1];
            r_fill_done <= w_fill_fin;
            r_cons_done <= w_cons_rel;
            if (w_fill_grant)  r_fill_pend <= 1'b0;
            else if (fill_req) r_fill_pend <= 1'b1;
            if (w_fill_grant) begin
                r_fill_busy <= 1'b1;
                r_fill_cnt  <= '0;
            end else if (w_fill_fin) begin
                r_fill_busy <= 1'b0;
                r_fill_cnt  <= '0;
                r_fill_ptr  <= !r_fill_ptr;
            end else if (w_fill_wr) begin
                r_fill_cnt <= r_fill_cnt + 32'd1;
            end
            if (w_cons_grant) begin
                r_cons_busy <= 1'b1;
                r_bank_sel  <= r_cons_ptr;
                r_rd_cnt    <= '0;
            end else if (w_cons_rel) begin
                r_cons_busy <= 1'b0;
                r_cons_ptr  <= !r_cons_ptr;
                r_rd_cnt    <= '0;
            end else if (w_cons_rd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (rd_en) r_rdata <= r_mem[{r_bank_sel, rd_addr}];
        end
    end

    // Bank index is the top address bit, so fill_addr wraps within its own bank.
    always_ff @(posedge clk) begin
        if (w_fill_wr) r_mem[{r_fill_ptr, fill_addr}] <= fill_wdata;
    end

    assign fill_busy     = r_fill_busy;
    assign fill_done     = r_fill_done;
    assign consume_busy  = r_cons_busy;
    assign consume_done  = r_cons_done;
    assign bank_sel      = r_bank_sel;
    assign rd_rdata      = r_rdata;
    assign o_dbg_bank_st = {r_bank[1], r_bank[0]};
endmodule

// File: tb/tb_rd_path_models.sv
// Bench for rd_path_models: table-driven address generator and DMA runs plus
// hand-written ping-pong buffer sequences, checked through expected-value queues.
module tb_rd_path_models;
    localparam int PAW    = 8;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ag_start = 1'b0, ag_req_ready = 1'b0;
    logic [31:0] ag_base_addr = '0, ag_bytes_total = '0, ag_stride_bytes = '0;
    logic        ag_req_valid, ag_req_last, ag_done;
    logic [31:0] ag_req_addr;
    logic [7:0]  ag_req_len;
    logic        rd_start_dma = 1'b0;
    logic [31:0] rd_start_addr = '0;
    logic [7:0]  rd_num_trans = '0;
    logic [31:0] rd_data;
    logic        rd_data_vld, rd_done;
    logic [31:0] seg_words = '0;
    logic        fill_req = 1'b0, fill_we = 1'b0, fill_busy, fill_done;
    logic [PAW-1:0] fill_addr = '0, rd_addr = '0;
    logic [31:0] fill_wdata = '0, rd_rdata;
    logic        consume_req = 1'b0, consume_busy, rd_en = 1'b0, cons_commit = 1'b0;
    logic        consume_done, bank_sel;
    logic [1:0]  dbg_ag_state, dbg_dma_state;
    logic [3:0]  dbg_bank_st;

    always #5 clk = ~clk;

    rd_path_models dut (
        .clk(clk), .rstn(rstn),
        .ag_start(ag_start), .ag_base_addr(ag_base_addr), .ag_bytes_total(ag_bytes_total),
        .ag_stride_bytes(ag_stride_bytes), .ag_req_valid(ag_req_valid), .ag_req_ready(ag_req_ready),
        .ag_req_addr(ag_req_addr), .ag_req_len(ag_req_len), .ag_req_last(ag_req_last), .ag_done(ag_done),
        .rd_start_dma(rd_start_dma), .rd_start_addr(rd_start_addr), .rd_num_trans(rd_num_trans),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_done(rd_done),
        .seg_words(seg_words), .fill_req(fill_req), .fill_busy(fill_busy), .fill_we(fill_we),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_done(fill_done),
        .consume_req(consume_req), .consume_busy(consume_busy), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_rdata(rd_rdata), .cons_commit(cons_commit), .consume_done(consume_done), .bank_sel(bank_sel),
        .o_dbg_ag_state(dbg_ag_state), .o_dbg_dma_state(dbg_dma_state), .o_dbg_bank_st(dbg_bank_st)
    );

    int errors = 0;
    int checks = 0;
    logic [40:0] ag_exp_q[$];
    logic [31:0] dma_exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [31:0] mdl_mem [512];
    logic        mdl_fill_ptr = 1'b0, mdl_cons_ptr = 1'b0;
    int ag_hs_cnt = 0, ag_done_cnt = 0, dma_beat_cnt = 0, rd_done_cnt = 0;
    int fill_done_cnt = 0, cons_done_cnt = 0;
    logic rd_en_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compares every presented request/beat/read against queue heads.
    always @(negedge clk) begin
        if (rstn) begin
            if (ag_req_valid) begin
                if (ag_exp_q.size() == 0) check("ag_unexpected_req", 64'(1), 64'(0));
                else begin
                    check("ag_req", 64'({ag_req_addr, ag_req_len, ag_req_last}), 64'(ag_exp_q[0]));
                    if (ag_req_ready) begin
                        void'(ag_exp_q.pop_front());
                        ag_hs_cnt++;
                    end
                end
            end
            if (rd_data_vld) begin
                if (dma_exp_q.size() == 0) check("dma_unexpected_beat", 64'(1), 64'(0));
                else check("dma_data", 64'(rd_data), 64'(dma_exp_q.pop_front()));
                dma_beat_cnt++;
            end
            if (rd_en_d) begin
                if (rd_exp_q.size() == 0) check("buf_unexpected_read", 64'(1), 64'(0));
                else check("buf_rdata", 64'(rd_rdata), 64'(rd_exp_q.pop_front()));
            end
            ag_done_cnt   += int'(ag_done);
            rd_done_cnt   += int'(rd_done);
            fill_done_cnt += int'(fill_done);
            cons_done_cnt += int'(consume_done);
        end
        rd_en_d = rd_en && rstn;
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] bytes;
        logic [31:0] stride;
        bit          toggle;
        int          exp_bursts;
    } ag_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  num;
        int          exp_lat;
        int          exp_done_at;
    } dma_vec_t;

    task automatic ag_model_push(input logic [31:0] base, input logic [31:0] bytes, input logic [31:0] stride);
        logic [31:0] beats, addr, b;
        beats = (bytes + 32'd3) / 32'd4;
        addr  = base;
        while (beats != 0) begin
            b = (beats > 32'd16) ? 32'd16 : beats;
            ag_exp_q.push_back({addr, 8'(b - 32'd1), (beats == b)});
            addr  = addr + b * 32'd4 + stride;
            beats = beats - b;
        end
    endtask

    task automatic ag_run(input ag_vec_t v);
        int d0, h0;
        d0 = ag_done_cnt;
        h0 = ag_hs_cnt;
        ag_model_push(v.base, v.bytes, v.stride);
        ag_base_addr = v.base; ag_bytes_total = v.bytes; ag_stride_bytes = v.stride;
        ag_req_ready = v.toggle ? 1'b0 : 1'b1;
        ag_start = 1'b1;
        tick();
        ag_start = 1'b0;
        check("ag_first_valid", 64'(ag_req_valid), 64'(v.exp_bursts != 0));
        if (v.exp_bursts == 0) check("ag_done_zero", 64'(ag_done), 64'(1));
        for (int c = 0; c < 600 && ag_done_cnt == d0; c++) begin
            if (v.toggle) ag_req_ready = 1'($urandom_range(0, 1));
            if (v.toggle && c == 2 && ag_req_valid && !(ag_req_last && ag_req_ready)) begin
                ag_base_addr = 32'hDEAD_0000;
                ag_start = 1'b1;
            end
            tick();
            ag_start = 1'b0;
        end
        ag_req_ready = 1'b0;
        tick();
        tick();
        check("ag_done_once", 64'(ag_done_cnt - d0), 64'(1));
        check("ag_burst_count", 64'(ag_hs_cnt - h0), 64'(v.exp_bursts));
        check("ag_queue_empty", 64'(ag_exp_q.size()), 64'(0));
    endtask

    task automatic dma_run(input dma_vec_t v);
        int b0, lat, done_at;
        b0 = dma_beat_cnt;
        for (int i = 0; i < int'(v.num); i++) dma_exp_q.push_back(v.addr + 32'(i) * 32'd4);
        rd_start_addr = v.addr; rd_num_trans = v.num;
        rd_start_dma = 1'b1;
        tick();
        rd_start_dma = 1'b0;
        lat = 0;
        done_at = 0;
        for (int c = 1; c <= 60; c++) begin
            if (lat == 0 && rd_data_vld) lat = c;
            if (rd_done) begin
                done_at = c;
                break;
            end
            if (c == 4 && v.num >= 8'd4) rd_start_dma = 1'b1;
            tick();
            rd_start_dma = 1'b0;
        end
        tick();
        check("dma_first_beat_lat", 64'(lat), 64'(v.exp_lat));
        check("dma_done_cycle", 64'(done_at), 64'(v.exp_done_at));
        check("dma_beat_count", 64'(dma_beat_cnt - b0), 64'(v.num));
        check("dma_done_pulse", 64'(rd_done), 64'(0));
    endtask

    task automatic fill_req_wait();
        int c;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        c = 0;
        while (!fill_busy && c < 50) begin
            tick();
            c++;
        end
        check("fill_busy_rise", 64'(fill_busy), 64'(1));
    endtask

    task automatic fill_write(input int n, input logic [31:0] dbase);
        int f0;
        f0 = fill_done_cnt;
        for (int i = 0; i < n; i++) begin
            fill_we = 1'b1;
            fill_addr = PAW'(i);
            fill_wdata = dbase + 32'(i);
            mdl_mem[{mdl_fill_ptr, PAW'(i)}] = dbase + 32'(i);
            tick();
        end
        fill_we = 1'b0;
        check("fill_done_pulse", 64'(fill_done), 64'(1));
        check("fill_no_early_done", 64'(fill_done_cnt - f0), 64'(0));
        check("fill_busy_drop", 64'(fill_busy), 64'(0));
        mdl_fill_ptr = !mdl_fill_ptr;
        tick();
        check("fill_done_single", 64'(fill_done), 64'(0));
    endtask

    task automatic consume_seg(input int nread);
        consume_req = 1'b1;
        tick();
        consume_req = 1'b0;
        check("cons_busy_rise", 64'(consume_busy), 64'(1));
        check("bank_sel", 64'(bank_sel), 64'(mdl_cons_ptr));
        for (int i = 0; i < nread; i++) begin
            rd_en = 1'b1;
            rd_addr = PAW'(i);
            rd_exp_q.push_back(mdl_mem[{mdl_cons_ptr, PAW'(i)}]);
            tick();
        end
        rd_en = 1'b0;
        tick();
        cons_commit = 1'b1;
        tick();
        cons_commit = 1'b0;
        check("cons_done_pulse", 64'(consume_done), 64'(1));
        check("cons_busy_drop", 64'(consume_busy), 64'(0));
        mdl_cons_ptr = !mdl_cons_ptr;
        tick();
        check("cons_done_single", 64'(consume_done), 64'(0));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ag_vec_t  ag_tab [5];
        dma_vec_t dma_tab [4];
        int f0, c0, c;
        ag_tab[0] = '{32'h1000, 32'd512, 32'd0,    1'b0, 8};
        ag_tab[1] = '{32'h2000, 32'd200, 32'd0,    1'b1, 4};
        ag_tab[2] = '{32'h3000, 32'd0,   32'd0,    1'b0, 0};
        ag_tab[3] = '{32'h4000, 32'd5,   32'h10,   1'b0, 1};
        ag_tab[4] = '{32'h0100, 32'd130, 32'h40,   1'b1, 3};
        dma_tab[0] = '{32'h0002_0000, 8'd16, RD_LAT, RD_LAT + 16};
        dma_tab[1] = '{32'h0000_0500, 8'd1,  RD_LAT, RD_LAT + 1};
        dma_tab[2] = '{32'h0000_0040, 8'd0,  0,      1};
        dma_tab[3] = '{32'hFFFF_FFF8, 8'd3,  RD_LAT, RD_LAT + 3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ag_valid", 64'(ag_req_valid), 64'(0));
        check("rst_ag_done", 64'(ag_done), 64'(0));
        check("rst_rd_vld", 64'(rd_data_vld), 64'(0));
        check("rst_fill_busy", 64'(fill_busy), 64'(0));
        check("rst_cons_busy", 64'(consume_busy), 64'(0));
        check("rst_states", 64'({dbg_ag_state, dbg_dma_state, dbg_bank_st}), 64'(0));
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) ag_run(ag_tab[i]);
        for (int i = 0; i < 4; i++) dma_run(dma_tab[i]);

        // Two fills, a stalled third fill, then drains releasing banks in order.
        seg_words = 32'd64;
        fill_req_wait();
        fill_write(64, 32'h100);
        check("bank0_full", 64'(dbg_bank_st), 64'(4'b0010));
        fill_req_wait();
        fill_write(64, 32'h200);
        check("both_full", 64'(dbg_bank_st), 64'(4'b1010));
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        repeat (5) tick();
        check("fill_stall", 64'(fill_busy), 64'(0));
        consume_seg(64);
        c = 0;
        while (!fill_busy && c < 10) begin
            tick();
            c++;
        end
        check("pending_fill_grant", 64'(fill_busy), 64'(1));
        check("bank0_refill", 64'(dbg_bank_st[1:0]), 64'(1));
        fill_write(64, 32'h300);
        consume_seg(64);
        consume_seg(64);
        consume_req = 1'b1;
        tick();
        consume_req = 1'b0;
        tick();
        check("cons_req_dropped", 64'(consume_busy), 64'(0));

        // Segment longer than a bank: address wraps, one fill_done at the end.
        seg_words = 32'd1024;
        fill_req_wait();
        fill_write(1024, 32'hA000_0000);
        consume_seg(8);

        seg_words = 32'd8;
        f0 = fill_done_cnt;
        c0 = cons_done_cnt;
        for (int k = 0; k < 12; k++) begin
            fill_req_wait();
            fill_write(8, 32'(k) << 16);
            consume_seg(8);
        end
        tick();
        check("loop_fill_done", 64'(fill_done_cnt - f0), 64'(12));
        check("loop_cons_done", 64'(cons_done_cnt - c0), 64'(12));

        // Reset in the middle of a burst, a DMA stream and a fill.
        seg_words = 32'd64;
        ag_model_push(32'h8000, 32'd512, 32'd0);
        ag_base_addr = 32'h8000; ag_bytes_total = 32'd512; ag_stride_bytes = 32'd0;
        ag_req_ready = 1'b0;
        ag_start = 1'b1;
        tick();
        ag_start = 1'b0;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 10; i++) dma_exp_q.push_back(32'h9000 + 32'(i) * 32'd4);
        rd_start_addr = 32'h9000; rd_num_trans = 8'd10;
        rd_start_dma = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_we = 1'b1;
            fill_addr = PAW'(i);
            fill_wdata = 32'hBEEF_0000 + 32'(i);
            tick();
            rd_start_dma = 1'b0;
        end
        fill_we = 1'b0;
        check("pre_rst_ag_valid", 64'(ag_req_valid), 64'(1));
        check("pre_rst_fill_busy", 64'(fill_busy), 64'(1));
        rstn = 1'b0;
        ag_exp_q.delete();
        dma_exp_q.delete();
        tick();
        check("midrst_ag", 64'({ag_req_valid, ag_req_addr, ag_req_len, ag_req_last, ag_done}), 64'(0));
        check("midrst_dma", 64'({rd_data_vld, rd_data, rd_done}), 64'(0));
        check("midrst_buf", 64'({fill_busy, fill_done, consume_busy, consume_done, bank_sel}), 64'(0));
        check("midrst_banks", 64'(dbg_bank_st), 64'(0));
        check("midrst_rdata", 64'(rd_rdata), 64'(0));
        rstn = 1'b1;
        mdl_fill_ptr = 1'b0;
        mdl_cons_ptr = 1'b0;
        tick();

        seg_words = 32'd8;
        fill_req_wait();
        fill_write(8, 32'h00C0_0000);
        check("post_rst_bank0_full", 64'(dbg_bank_st), 64'(4'b0010));
        consume_seg(8);
        tick();
        check("final_queues_empty", 64'(ag_exp_q.size() + dma_exp_q.size() + rd_exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
